decode_stage: RTL and testbench

//  Registered decode pipeline stage between fetch and execute. Decodes one 32-bit instruction
//  (R, load, ADDI, store, branch, JAL) per cycle into a control bundle held in an output register.

---
 rtl/decode_stage_if.sv | 58 +++++
 rtl/decode_stage.sv | 199 +++++++++++++++++++
 tb/tb_decode_stage.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/decode_stage_if.sv
// decode_stage_if
//   Bundles every non-clock signal of the decode stage: the fetch-side
//   handshake (in_*), the execute-side handshake and control bundle (out_*),
//   the flush request and the load write-back notification (wb_*).
//
//   Handshake semantics (both sides): a transfer happens on a rising edge
//   where valid && ready are both high.
//   - The source must not drop valid or change its payload until the
//     transfer happens.
//   - Ready may depend combinationally on valid.
//
//   modport slave  : the decode stage's view.
//   modport master : the surrounding fetch/execute/testbench view.
interface decode_stage_if #(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5
);
    logic              in_valid;
    logic              in_ready;
    logic [31:0]       in_ir;
    logic [XLEN-1:0]   in_pc;
    logic              flush;
    logic              out_valid;
    logic              out_ready;
    logic [13:0]       out_op;
    logic              out_y_sel;
    logic [REG_AW-1:0] out_addr_a;
    logic [REG_AW-1:0] out_addr_b;
    logic [REG_AW-1:0] out_addr_d;
    logic [XLEN-1:0]   out_immed;
    logic [XLEN-1:0]   out_pc;
    logic              out_read_mmu;
    logic              out_write_mmu;
    logic              out_byte_sel;
    logic              out_write;
    logic              out_branch;
    logic              out_load;
    logic              out_jump;
    logic              out_illegal;
    logic              wb_valid;
    logic [REG_AW-1:0] wb_addr;

    modport slave (
        input  in_valid, in_ir, in_pc, flush, out_ready, wb_valid, wb_addr,
        output in_ready, out_valid, out_op, out_y_sel, out_addr_a, out_addr_b,
               out_addr_d, out_immed, out_pc, out_read_mmu, out_write_mmu,
               out_byte_sel, out_write, out_branch, out_load, out_jump,
               out_illegal
    );

    modport master (
        output in_valid, in_ir, in_pc, flush, out_ready, wb_valid, wb_addr,
        input  in_ready, out_valid, out_op, out_y_sel, out_addr_a, out_addr_b,
               out_addr_d, out_immed, out_pc, out_read_mmu, out_write_mmu,
               out_byte_sel, out_write, out_branch, out_load, out_jump,
               out_illegal
    );
endinterface

// File: rtl/decode_stage.sv
// decode_stage
//   Registered decode pipeline stage between fetch and execute.
//   - Decodes one instruction per cycle: R, LOAD, ADDI, STORE, BRANCH or JAL.
//   - The decoded control bundle is held in an output register.
//   - A load scoreboard holds back instructions whose source registers are
//     still waiting for load data.
//   Ports:
//     clk   : clock
//     reset : synchronous, active-high reset
//     bus   : decode_stage_if.slave. Carries the fetch handshake (in_*), the
//             execute handshake and bundle (out_*), flush, and the load
//             write-back notification (wb_valid / wb_addr).
module decode_stage #(
    parameter int XLEN      = 32,
    parameter int REG_AW    = 5,
    parameter int SB_ENABLE = 1
) (
    input  logic          clk,
    input  logic          reset,
    decode_stage_if.slave bus
);
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_ADDI   = 7'b0010011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam int         NREG      = 2 ** REG_AW;

    // Instruction fields
    logic [6:0]        opcode;
    logic [2:0]        funct3;
    logic [6:0]        funct7;
    logic [REG_AW-1:0] rs1, rs2, rd;

    assign opcode = bus.in_ir[6:0];
    assign funct3 = bus.in_ir[14:12];
    assign funct7 = bus.in_ir[31:25];
    assign rs1    = bus.in_ir[15 +: REG_AW];
    assign rs2    = bus.in_ir[20 +: REG_AW];
    assign rd     = bus.in_ir[7 +: REG_AW];

    // Combinational decode of the incoming word
    logic [13:0]       d_op;
    logic              d_y_sel;
    logic [REG_AW-1:0] d_addr_a, d_addr_b, d_addr_d;
    logic [XLEN-1:0]   d_immed;
    logic              d_read_mmu, d_write_mmu, d_byte_sel, d_write;
    logic              d_branch, d_load, d_jump, d_illegal;
    logic              use_rs1, use_rs2;

    always_comb begin
        d_op        = '0;
        d_y_sel     = 1'b0;
        d_addr_a    = rs1;
        d_addr_b    = rs2;
        d_addr_d    = rd;
        d_immed     = '0;
        d_read_mmu  = 1'b0;
        d_write_mmu = 1'b0;
        d_byte_sel  = 1'b0;
        d_write     = 1'b0;
        d_branch    = 1'b0;
        d_load      = 1'b0;
        d_jump      = 1'b0;
        d_illegal   = 1'b0;
        use_rs1     = 1'b0;
        use_rs2     = 1'b0;
        unique case (opcode)
            OP_R: begin
                d_op    = {opcode, funct7};
                d_y_sel = 1'b1;
                d_write = 1'b1;
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
            end
            OP_LOAD: begin
                d_op       = {4'b0, opcode, funct3};
                d_immed    = {{(XLEN-12){bus.in_ir[31]}}, bus.in_ir[31:20]};
                d_read_mmu = 1'b1;
                d_byte_sel = (funct3 == 3'b000);
                d_load     = 1'b1;
                d_write    = 1'b1;
                use_rs1    = 1'b1;
            end
            OP_ADDI: begin
                d_op    = {4'b0, opcode, funct3};
                d_immed = {{(XLEN-12){bus.in_ir[31]}}, bus.in_ir[31:20]};
                d_write = 1'b1;
                use_rs1 = 1'b1;
            end
            OP_STORE: begin
                d_op        = {4'b0, opcode, funct3};
                d_immed     = {{(XLEN-12){bus.in_ir[31]}}, bus.in_ir[31:25],
                               bus.in_ir[11:7]};
                d_write_mmu = 1'b1;
                d_byte_sel  = (funct3 == 3'b000);
                use_rs1     = 1'b1;
                use_rs2     = 1'b1;
            end
            OP_BRANCH: begin
                d_op     = {4'b0, opcode, funct3};
                d_immed  = {{(XLEN-13){bus.in_ir[31]}}, bus.in_ir[31], bus.in_ir[7],
                            bus.in_ir[30:25], bus.in_ir[11:8], 1'b0};
                d_branch = 1'b1;
                use_rs1  = 1'b1;
                use_rs2  = 1'b1;
            end
            OP_JAL: begin
                d_op    = {7'b0, opcode};
                d_immed = {{(XLEN-21){bus.in_ir[31]}}, bus.in_ir[31], bus.in_ir[19:12],
                           bus.in_ir[20], bus.in_ir[30:21], 1'b0};
                d_jump  = 1'b1;
                d_write = 1'b1;
            end
            default: begin
                // Unknown opcode: only the illegal flag survives.
                d_addr_a  = '0;
                d_addr_b  = '0;
                d_addr_d  = '0;
                d_illegal = 1'b1;
            end
        endcase
        // x0 is hard-wired, so writes to it are dropped.
        if (rd == '0) d_write = 1'b0;
    end

    // Load-use scoreboard. A bit is set when a load leaves the stage and
    // cleared when its data is written back. There is no bypass: a cleared bit
    // only releases a consumer after the clear has been registered.
    logic [NREG-1:0] sb, sb_next;
    logic            hazard, accept, issue;

    assign issue  = bus.out_valid && bus.out_ready;
    assign hazard = (SB_ENABLE != 0) && bus.in_valid &&
                    ((use_rs1 && sb[rs1]) || (use_rs2 && sb[rs2]));
    assign bus.in_ready = (!bus.out_valid || bus.out_ready) && !hazard && !bus.flush;
    assign accept = bus.in_valid && bus.in_ready;

    always_comb begin
        sb_next = sb;
        if (bus.wb_valid) sb_next[bus.wb_addr] = 1'b0;
        // A set after the clear makes the set win when both hit one register.
        if (issue && bus.out_load && bus.out_addr_d != '0)
            sb_next[bus.out_addr_d] = 1'b1;
        sb_next[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) sb <= '0;
        else       sb <= sb_next;
    end

    // Output valid. Flush wins over everything else. A new accept refills the
    // register. Otherwise the bundle drains once it has been issued.
    always_ff @(posedge clk) begin
        if (reset)          bus.out_valid <= 1'b0;
        else if (bus.flush) bus.out_valid <= 1'b0;
        else if (accept)    bus.out_valid <= 1'b1;
        else if (issue)     bus.out_valid <= 1'b0;
    end

    // Bundle register. It only loads on accept, so it is stable while held.
    always_ff @(posedge clk) begin
        if (reset) begin
            bus.out_op        <= '0;
            bus.out_y_sel     <= 1'b0;
            bus.out_addr_a    <= '0;
            bus.out_addr_b    <= '0;
            bus.out_addr_d    <= '0;
            bus.out_immed     <= '0;
            bus.out_pc        <= '0;
            bus.out_read_mmu  <= 1'b0;
            bus.out_write_mmu <= 1'b0;
            bus.out_byte_sel  <= 1'b0;
            bus.out_write     <= 1'b0;
            bus.out_branch    <= 1'b0;
            bus.out_load      <= 1'b0;
            bus.out_jump      <= 1'b0;
            bus.out_illegal   <= 1'b0;
        end else if (accept) begin
            bus.out_op        <= d_op;
            bus.out_y_sel     <= d_y_sel;
            bus.out_addr_a    <= d_addr_a;
            bus.out_addr_b    <= d_addr_b;
            bus.out_addr_d    <= d_addr_d;
            bus.out_immed     <= d_immed;
            bus.out_pc        <= bus.in_pc;
            bus.out_read_mmu  <= d_read_mmu;
            bus.out_write_mmu <= d_write_mmu;
            bus.out_byte_sel  <= d_byte_sel;
            bus.out_write     <= d_write;
            bus.out_branch    <= d_branch;
            bus.out_load      <= d_load;
            bus.out_jump      <= d_jump;
            bus.out_illegal   <= d_illegal;
        end
    end
endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage
//   Directed testbench for decode_stage. Inputs change 1 ns after a rising
//   edge, and outputs are sampled before the next edge.
module tb_decode_stage;
    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   checks   = 0;
    int   failures = 0;

    decode_stage_if #(.XLEN(32), .REG_AW(5)) bus ();

    decode_stage #(.XLEN(32), .REG_AW(5), .SB_ENABLE(1)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic present(input logic [31:0] ir, input logic [31:0] pc);
        bus.in_valid = 1'b1;
        bus.in_ir    = ir;
        bus.in_pc    = pc;
        #1;
    endtask

    task automatic idle();
        bus.in_valid = 1'b0;
        #1;
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_ir     = '0;
        bus.in_pc     = '0;
        bus.flush     = 1'b0;
        bus.out_ready = 1'b1;
        bus.wb_valid  = 1'b0;
        bus.wb_addr   = '0;
        tick();
        tick();
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_out_op",    bus.out_op, 0);
        chk("rst_out_immed", bus.out_immed, 0);
        reset = 1'b0;
        #1;
        chk("rst_in_ready", bus.in_ready, 1);

        // ADD x3,x1,x2
        present(32'h002081B3, 32'h100);
        chk("add_in_ready", bus.in_ready, 1);
        tick();
        idle();
        chk("add_valid", bus.out_valid, 1);
        chk("add_op",    bus.out_op, {7'b0110011, 7'b0000000});
        chk("add_a",     bus.out_addr_a, 1);
        chk("add_b",     bus.out_addr_b, 2);
        chk("add_d",     bus.out_addr_d, 3);
        chk("add_ysel",  bus.out_y_sel, 1);
        chk("add_write", bus.out_write, 1);
        chk("add_immed", bus.out_immed, 0);
        chk("add_pc",    bus.out_pc, 32'h100);
        tick();
        chk("drain_valid", bus.out_valid, 0);

        // LW x5,8(x1) then dependent ADD x6,x5,x0
        present(32'h0080A283, 32'h104);
        tick();
        idle();
        chk("lw_load",  bus.out_load, 1);
        chk("lw_rd",    bus.out_read_mmu, 1);
        chk("lw_immed", bus.out_immed, 8);
        chk("lw_ysel",  bus.out_y_sel, 0);
        chk("lw_bsel",  bus.out_byte_sel, 0);
        chk("lw_op",    bus.out_op, {4'b0, 7'b0000011, 3'b010});
        chk("lw_d",     bus.out_addr_d, 5);
        tick();                                  // LW issues, sb[5] set
        present(32'h00028333, 32'h108);
        chk("use_stall0", bus.in_ready, 0);
        tick();
        chk("use_stall1", bus.in_ready, 0);
        chk("use_nvalid", bus.out_valid, 0);
        bus.wb_valid = 1'b1;
        bus.wb_addr  = 5'd5;
        #1;
        chk("use_stall_wb", bus.in_ready, 0);    // clear not yet registered
        tick();
        bus.wb_valid = 1'b0;
        #1;
        chk("use_release", bus.in_ready, 1);
        tick();
        idle();
        chk("use_valid", bus.out_valid, 1);
        chk("use_a",     bus.out_addr_a, 5);
        chk("use_d",     bus.out_addr_d, 6);
        chk("use_pc",    bus.out_pc, 32'h108);

        // SB x2,4(x1), then BEQ and JAL back to back
        present(32'h00208223, 32'h10C);
        chk("sb_in_ready", bus.in_ready, 1);
        tick();
        chk("sb_wmmu",  bus.out_write_mmu, 1);
        chk("sb_bsel",  bus.out_byte_sel, 1);
        chk("sb_immed", bus.out_immed, 4);
        chk("sb_ysel",  bus.out_y_sel, 0);
        chk("sb_write", bus.out_write, 0);
        present(32'hFE208CE3, 32'h110);
        chk("beq_in_ready", bus.in_ready, 1);
        tick();
        chk("beq_branch", bus.out_branch, 1);
        chk("beq_immed",  bus.out_immed, 32'hFFFFFFF8);
        chk("beq_op",     bus.out_op, {4'b0, 7'b1100011, 3'b000});
        present(32'h0100006F, 32'h114);
        tick();
        chk("jal_jump",  bus.out_jump, 1);
        chk("jal_immed", bus.out_immed, 16);
        chk("jal_write", bus.out_write, 0);
        chk("jal_op",    bus.out_op, {7'b0, 7'b1101111});

        // Hold for 3 cycles, then flush while an ADD waits at the input
        bus.out_ready = 1'b0;
        present(32'h002081B3, 32'h118);
        chk("hold_in_ready", bus.in_ready, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("hold_valid", bus.out_valid, 1);
            chk("hold_immed", bus.out_immed, 16);
            chk("hold_pc",    bus.out_pc, 32'h114);
        end
        bus.flush = 1'b1;
        #1;
        chk("flush_in_ready", bus.in_ready, 0);
        tick();
        bus.flush = 1'b0;
        idle();
        chk("flush_valid",   bus.out_valid, 0);
        chk("flush_noacc",   bus.out_pc, 32'h114);
        bus.out_ready = 1'b1;

        // Flush together with out_ready: the held load still sets sb
        bus.out_ready = 1'b0;
        present(32'h0080A283, 32'h120);
        tick();
        idle();
        chk("fl_ld_valid", bus.out_valid, 1);
        bus.flush     = 1'b1;
        bus.out_ready = 1'b1;
        tick();
        bus.flush = 1'b0;
        present(32'h00028333, 32'h124);
        chk("fl_ld_valid0", bus.out_valid, 0);
        chk("fl_ld_stall",  bus.in_ready, 0);

        // Reset while stalled on sb[5]
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        chk("rst2_valid",    bus.out_valid, 0);
        chk("rst2_in_ready", bus.in_ready, 1);
        chk("rst2_pc",       bus.out_pc, 0);
        tick();
        idle();
        chk("rst2_issue", bus.out_valid, 1);

        // Illegal opcode 0x7F
        present(32'h0000007F, 32'h128);
        tick();
        idle();
        chk("ill_flag",   bus.out_illegal, 1);
        chk("ill_write",  bus.out_write, 0);
        chk("ill_load",   bus.out_load, 0);
        chk("ill_branch", bus.out_branch, 0);
        chk("ill_jump",   bus.out_jump, 0);
        chk("ill_ysel",   bus.out_y_sel, 0);
        chk("ill_mmu",    {bus.out_read_mmu, bus.out_write_mmu, bus.out_byte_sel}, 0);
        chk("ill_immed",  bus.out_immed, 0);

        // ADDI x0,x0,1: write to x0 dropped
        present(32'h00100013, 32'h12C);
        tick();
        chk("addi0_write", bus.out_write, 0);
        chk("addi0_immed", bus.out_immed, 1);
        chk("addi0_ill",   bus.out_illegal, 0);

        // LW x0,0(x0) must not mark x0 busy; ADDI x1,x0,0 then issues freely
        present(32'h00002003, 32'h130);
        tick();
        idle();
        chk("lw0_load", bus.out_load, 1);
        tick();
        present(32'h00000093, 32'h134);
        chk("x0_no_stall", bus.in_ready, 1);
        tick();
        idle();
        chk("x0_issue", bus.out_pc, 32'h134);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Watchdog on the whole run
    initial begin
        #20000;
        failures++;
        $display("FAIL watchdog observed=timeout expected=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end
endmodule
